i2s_sample_tx: RTL
==================

// Module: i2s_sample_tx
// PURPOSE
//   Output end of the effects chain: accepts processed 16-bit samples (valid strobe, no backpressure)
//   and serialises them as a Philips-I2S stream (BCLK/LRCLK/SDATA) toward the audio DAC/codec.
//   Mono source: each frame carries the same sample in left and right slots. BCLK/LRCLK are
//   generated internally from clk; the block is the I2S clock master.
// PARAMETERS
//   sample_width  16  bits per sample, two's complement, MSB-first on the wire
//   slot_width    32  BCLK periods per channel slot; must be >= sample_width+1
//   bclk_div      4   clk cycles per BCLK half-period; must be >= 1
// PORTS
//   clk          in   1             system clock
//   rst          in   1             asynchronous reset, active-high
//   valid        in   1             1-clk strobe: in_sample holds a new sample
//   in_sample    in   sample_width  sample to transmit
//   ou_bclk      out  1             I2S bit clock
//   ou_lrclk     out  1             I2S word select, 0 = left slot, 1 = right slot
//   ou_sdata     out  1             I2S serial data
//   ou_frame     out  1             1-clk pulse in the cycle a new frame is loaded
//   ou_underrun  out  1             1-clk pulse: frame loaded with no new sample (previous repeated)
//   ou_overrun   out  1             1-clk pulse: valid arrived while a sample was already pending
// BEHAVIOUR
//   - Reset: all outputs 0; div_cnt=0, bit_idx=0, holding=0, pending=0, shift=0.
//   - Divider: div_cnt counts 0..bclk_div-1; on wrap, bclk toggles. A falling edge (fe) is the
//     clk cycle in which div_cnt wraps while bclk=1. All outputs are registered; all state changes occur on clk.
//   - bit_idx (0..2*slot_width-1) advances on each fe, wrapping to 0. ou_lrclk = (bit_idx >= slot_width).
//   - Slot position p = bit_idx mod slot_width. ou_sdata = 0 at p=0 (I2S one-bit delay);
//     sample bit [sample_width-p] for p=1..sample_width; 0 for p>sample_width (padding).
//   - Frame load: at the fe where bit_idx wraps 2*slot_width-1 -> 0, shift <= sample, ou_frame pulses.
//     The sample used is: in_sample if valid in that same cycle (bypass, pending cleared); else
//     holding if pending=1 (pending cleared); else holding again (repeat) with ou_underrun pulse.
//   - valid outside the load cycle: holding <= in_sample, pending <= 1; if pending was already 1,
//     the old value is overwritten and ou_overrun pulses.
//   - shift is held for the whole frame: right slot repeats the left-slot sample bit-for-bit.
//   - Latency: MSB of a sample reaches ou_sdata at the fe of bit_idx=1 of the first frame loaded after
//     its valid strobe.
//   - Frame period = 2*slot_width*2*bclk_div clk cycles (default 512).
//   - rst mid-frame: immediate return to reset state; pending sample discarded; first frame after
//     release transmits zeros, then the first load occurs after 2*slot_width BCLK periods.
// TESTING
//   1. bclk_div=2, slot_width=32: after rst, ou_bclk period = 4 clk, ou_lrclk period = 256 clk, 50% duty.
//   2. valid with in_sample=16'hA5C3 -> after next ou_frame, left and right slots on ou_sdata read
//      0,1010010111000011, then 15 zeros; ou_underrun=0.
//   3. No valid for two frames after 16'h8001 -> second frame repeats 16'h8001, ou_underrun pulses once.
//   4. valid 16'h1111 then 16'h2222 within one frame -> ou_overrun pulses once; 16'h2222 transmitted.
//   5. valid 16'h7FFF in the exact ou_frame load cycle -> 16'h7FFF sent in that frame (bypass).
//   6. Assert rst at bit_idx=20 -> ou_bclk, ou_lrclk, ou_sdata are 0 immediately; pending sample is not sent.

Source files
------------

// File: rtl/i2s_sample_tx.sv
// ---------------------------------------------------------------------------
// i2s_sample_tx
//   Output stage of the effects chain. Takes processed mono samples (valid
//   strobe, no backpressure) and transmits them as a Philips-I2S stream with
//   this block acting as clock master. Every frame carries the same sample in
//   the left and right slots, MSB first, one BCLK after the LRCLK edge, with
//   zero padding to the end of the slot.
//
// Parameters
//   sample_width  bits per sample (two's complement)
//   slot_width    BCLK periods per channel slot, >= sample_width+1
//   bclk_div      clk cycles per BCLK half-period, >= 1
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   valid        1-clk strobe, in_sample carries a new sample
//   in_sample    sample to transmit
//   ou_bclk      I2S bit clock
//   ou_lrclk     I2S word select (0 = left slot, 1 = right slot)
//   ou_sdata     I2S serial data, changes on the BCLK falling edge
//   ou_frame     1-clk pulse after a new frame has been loaded
//   ou_underrun  1-clk pulse: frame loaded without a fresh sample (repeat)
//   ou_overrun   1-clk pulse: valid arrived while a sample was still pending
// ---------------------------------------------------------------------------
module i2s_sample_tx #(
    parameter int sample_width = 16,
    parameter int slot_width   = 32,
    parameter int bclk_div     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [sample_width-1:0] in_sample,
    output logic                    ou_bclk,
    output logic                    ou_lrclk,
    output logic                    ou_sdata,
    output logic                    ou_frame,
    output logic                    ou_underrun,
    output logic                    ou_overrun
);

    localparam int frame_bits = 2 * slot_width;
    localparam int idx_w      = $clog2(frame_bits);
    localparam int pos_w      = $clog2(slot_width);
    localparam int slot_pad   = 1 << pos_w;
    localparam int div_w      = (bclk_div > 1) ? $clog2(bclk_div) : 1;

    localparam logic [div_w-1:0] div_last = div_w'(bclk_div - 1);
    localparam logic [idx_w-1:0] idx_last = idx_w'(frame_bits - 1);
    localparam logic [idx_w-1:0] slot_len = idx_w'(slot_width);

    // State
    logic [div_w-1:0]        div_cnt_reg;
    logic                    bclk_reg;
    logic [idx_w-1:0]        bit_idx_reg;
    logic                    lrclk_reg;
    logic                    sdata_reg;
    logic [sample_width-1:0] shift_reg;
    logic [sample_width-1:0] holding_reg;
    logic                    pending_reg;
    logic                    frame_reg;
    logic                    underrun_reg;
    logic                    overrun_reg;

    // Next-state helpers
    logic             div_wrap;
    logic             fe;
    logic             load;
    logic [idx_w-1:0] bit_idx_next;
    logic             lrclk_next;
    logic [pos_w-1:0] pos_next;

    // Wire image of one slot, indexed by slot position p: p=0 is the I2S
    // one-bit delay, p=1..sample_width carry the sample MSB first, the rest
    // is padding. Built from the frame register so both slots are identical.
    logic [slot_pad-1:0] slot_bits;

    for (genvar gi = 0; gi < slot_pad; gi++) begin : g_slot_bits
        if (gi >= 1 && gi <= sample_width) begin : g_data
            assign slot_bits[gi] = shift_reg[sample_width-gi];
        end else begin : g_pad
            assign slot_bits[gi] = 1'b0;
        end
    end

    always_comb begin
        div_wrap     = (div_cnt_reg == div_last);
        fe           = div_wrap && bclk_reg;
        load         = fe && (bit_idx_reg == idx_last);
        bit_idx_next = bit_idx_reg;
        if (fe) begin
            bit_idx_next = load ? '0 : bit_idx_reg + 1'b1;
        end
        lrclk_next = (bit_idx_next >= slot_len);
        pos_next   = pos_w'(lrclk_next ? bit_idx_next - slot_len : bit_idx_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg  <= '0;
            bclk_reg     <= 1'b0;
            bit_idx_reg  <= '0;
            lrclk_reg    <= 1'b0;
            sdata_reg    <= 1'b0;
            shift_reg    <= '0;
            holding_reg  <= '0;
            pending_reg  <= 1'b0;
            frame_reg    <= 1'b0;
            underrun_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            div_cnt_reg <= div_wrap ? '0 : div_cnt_reg + 1'b1;
            if (div_wrap) begin
                bclk_reg <= ~bclk_reg;
            end

            // LRCLK and SDATA move together with BCLK falling, so the
            // receiver samples stable data on the next rising edge.
            if (fe) begin
                bit_idx_reg <= bit_idx_next;
                lrclk_reg   <= lrclk_next;
                sdata_reg   <= slot_bits[pos_next];
            end

            frame_reg    <= load;
            underrun_reg <= load && !valid && !pending_reg;
            // A strobe on top of a pending sample drops that sample, also
            // when the strobe lands in the load cycle and bypasses it.
            overrun_reg  <= valid && pending_reg;

            if (load) begin
                // holding always mirrors the last sample put on the wire, so
                // an underrun repeats exactly what was sent before.
                if (valid) begin
                    shift_reg   <= in_sample;
                    holding_reg <= in_sample;
                end else begin
                    shift_reg <= holding_reg;
                end
                pending_reg <= 1'b0;
            end else if (valid) begin
                holding_reg <= in_sample;
                pending_reg <= 1'b1;
            end
        end
    end

    assign ou_bclk     = bclk_reg;
    assign ou_lrclk    = lrclk_reg;
    assign ou_sdata    = sdata_reg;
    assign ou_frame    = frame_reg;
    assign ou_underrun = underrun_reg;
    assign ou_overrun  = overrun_reg;

endmodule
